mux_key: RTL and testbench
==========================

Name: mux_key

Overview:
- Parameterised key-lookup multiplexer: a packed table of (key, data) pairs is searched for entries whose key equals the select input, and the matching data is returned.
- Used throughout the core for byte/half selection, load-extension and store-mask selection.
- Provides a combinational result plus a registered copy and match flags.

Parameters:
- NR_KEY, 2, number of (key, data) entries in the table; at least 1.
- KEY_LEN, 1, width of the key field and of the select input; at least 1.
- DATA_LEN, 1, width of the data field and of the output; at least 1.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- key  input  KEY_LEN  select value compared against every table key.
- lut  input  NR_KEY*(KEY_LEN+DATA_LEN)  packed table.
- out  output  DATA_LEN  combinational lookup result.
- hit  output  1  combinational: at least one entry key equals key.
- multi_hit  output  1  combinational: two or more entries match.
- out_q  output  DATA_LEN  out registered on clk_i.
- hit_q  output  1  hit registered on clk_i.

Behaviour:
- Entry width W = KEY_LEN + DATA_LEN.
- Entry i occupies lut[(i+1)*W-1 : i*W]. Within an entry, the key is the upper KEY_LEN bits and the data is the lower DATA_LEN bits.
- Consequence of this packing: in a concatenation {k_a, d_a, k_b, d_b, ...}, the first-listed pair is entry NR_KEY-1.
- match[i] = (entry i key == key). Bitwise equality; X/Z handling is not specified.
- out = bitwise OR of the data of every matching entry. With a single match this is that entry's data; with no match out = 0 (see Optional Feature).
- Duplicate keys are legal: the results are OR-ed and multi_hit is asserted. Callers must avoid duplicates when OR-ing is not intended.
- hit = OR of match; multi_hit = 1 when popcount(match) >= 2.
- out, hit and multi_hit are purely combinational: zero latency, with no dependence on clk_i or rst_i.
- Registered stage: on every rising clk_i, out_q <= out and hit_q <= hit. There is no enable; the stage samples every cycle. Latency is 1 cycle.
- Reset: while rst_i=1, out_q=0 and hit_q=0 immediately (asynchronous).
  - After rst_i deasserts, the first rising edge loads the current lookup.
  - Combinational outputs are unaffected by reset.
- Reset asserted mid-operation: out_q/hit_q clear at once; out continues to track key and lut.
- NR_KEY=1: out = data when the single key matches, else 0; multi_hit is constantly 0.
- Key values not present in the table fall into the no-match case. Full decode is not required.

Optional Feature:
- Macro MUX_KEY_DEFAULT_EN.
- When defined, an extra input default_i (DATA_LEN) is added. When hit=0, out = default_i; otherwise out = OR of the matching data. out_q follows this out.
- When undefined, default_i does not exist and no-match yields out = 0.

Test Plan:
- NR_KEY=4, KEY_LEN=2, DATA_LEN=8; lut = {2'b00,8'h11, 2'b01,8'h22, 2'b10,8'h33, 2'b11,8'h44}; key=2'b10 -> out=8'h33, hit=1, multi_hit=0. One cycle later -> out_q=8'h33, hit_q=1.
- NR_KEY=4, KEY_LEN=3, DATA_LEN=4; keys 0..3 with data 4'b0000/0001/0011/1111; key=3'd5 -> out=4'h0, hit=0. With MUX_KEY_DEFAULT_EN and default_i=4'hA -> out=4'hA.
- Duplicate keys: entries {1'b1,4'h3, 1'b1,4'hC}; key=1 -> out=4'hF, hit=1, multi_hit=1.
- Sweep all key values 0..2^KEY_LEN-1 on the first configuration; each step -> out matches a reference model in the same cycle, and out_q equals the previous cycle's out.
- Assert rst_i asynchronously between clock edges while key=2'b11 -> out_q=0 and hit_q=0 immediately, while out=8'h44. Release rst_i -> next edge out_q=8'h44.
- NR_KEY=1, KEY_LEN=1, DATA_LEN=16; entry {1'b0,16'hBEEF}; key=0 -> out=16'hBEEF; key=1 -> out=16'h0000, multi_hit=0.

Source files
------------

// File: rtl/mux_key.sv
// -----------------------------------------------------------------------------
// mux_key -- parameterised key-lookup multiplexer.
//
// Searches a packed table of (key, data) pairs for every entry whose key equals
// the select input.
// - The combinational result is the OR of the matching data.
// - Registered copies of the result and of the hit flag are also provided.
//
// Table packing:
// - Entry width W = KEY_LEN + DATA_LEN.
// - Entry i lives in lut[(i+1)*W-1 : i*W], with the key in the upper KEY_LEN
//   bits and the data in the lower DATA_LEN bits.
// - In a concatenation {k_a, d_a, k_b, d_b, ...} the first-listed pair is
//   therefore entry NR_KEY-1.
//
// Parameters:
//   NR_KEY    number of table entries (>= 1)
//   KEY_LEN   key / select width     (>= 1)
//   DATA_LEN  data / output width    (>= 1)
//
// Ports:
//   clk_i      in   1                          clock (registered stage)
//   rst_i      in   1                          async active-high reset, clears
//                                              out_q/hit_q only
//   key        in   KEY_LEN                    select value
//   lut        in   NR_KEY*(KEY_LEN+DATA_LEN)  packed table
//   default_i  in   DATA_LEN                   only with MUX_KEY_DEFAULT_EN:
//                                              value returned when no key
//                                              matches
//   out        out  DATA_LEN                   combinational lookup result
//   hit        out  1                          combinational: >= 1 entry matches
//   multi_hit  out  1                          combinational: >= 2 entries match
//   out_q      out  DATA_LEN                   out registered on clk_i
//   hit_q      out  1                          hit registered on clk_i
//
// Optional feature macro: MUX_KEY_DEFAULT_EN
//   - Defined: adds default_i, which drives out when hit=0.
//   - Undefined: a miss yields out=0.
// -----------------------------------------------------------------------------
module mux_key #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [KEY_LEN-1:0]                    key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
`ifdef MUX_KEY_DEFAULT_EN
  input  logic [DATA_LEN-1:0]                   default_i,
`endif
  output logic [DATA_LEN-1:0]                   out,
  output logic                                  hit,
  output logic                                  multi_hit,
  output logic [DATA_LEN-1:0]                   out_q,
  output logic                                  hit_q
);

  localparam int W = KEY_LEN + DATA_LEN;

  // Unpacked views of the table fields
  logic [KEY_LEN-1:0]  ent_key  [NR_KEY];
  logic [DATA_LEN-1:0] ent_data [NR_KEY];
  logic [NR_KEY-1:0]   match;

  for (genvar i = 0; i < NR_KEY; i++) begin : g_entry
    assign ent_key[i]  = lut[i*W+DATA_LEN +: KEY_LEN];
    assign ent_data[i] = lut[i*W +: DATA_LEN];
    assign match[i]    = (ent_key[i] == key);
  end

  // OR-reduce matching data and detect a second match.
  // - any_match is set after the first match, so a later match reports a
  //   duplicate through dup_match.
  // - This avoids a full popcount, since only ">= 2" is needed.
  logic [DATA_LEN-1:0] or_data;
  logic                any_match;
  logic                dup_match;

  always_comb begin
    or_data   = '0;
    any_match = 1'b0;
    dup_match = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (match[i]) begin
        or_data   = or_data | ent_data[i];
        dup_match = dup_match | any_match;
        any_match = 1'b1;
      end
    end
  end

`ifdef MUX_KEY_DEFAULT_EN
  assign out = any_match ? or_data : default_i;
`else
  assign out = or_data;
`endif

  assign hit       = any_match;
  assign multi_hit = dup_match;

  // Registered copy. It samples every cycle and has no enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else begin
      out_q <= out;
      hit_q <= hit;
    end
  end

endmodule

// File: tb/tb_mux_key.sv
// -----------------------------------------------------------------------------
// tb_mux_key -- self-checking bench for mux_key.
//
// Four instances are exercised:
//   A: NR_KEY=4, KEY_LEN=2, DATA_LEN=8
//   B: NR_KEY=4, KEY_LEN=3, DATA_LEN=4
//   C: NR_KEY=2, KEY_LEN=1, DATA_LEN=4
//   D: NR_KEY=1, KEY_LEN=1, DATA_LEN=16
//
// Expected values come from a reference model that slices the table with plain
// shift/mask arithmetic.
// -----------------------------------------------------------------------------
module tb_mux_key;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  // ---------------- instance A ----------------
  logic [1:0]  a_key;
  logic [39:0] a_lut;
  logic [7:0]  a_def;
  logic [7:0]  a_out, a_out_q;
  logic        a_hit, a_mh, a_hit_q;

  mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .key(a_key), .lut(a_lut),
`ifdef MUX_KEY_DEFAULT_EN
    .default_i(a_def),
`endif
    .out(a_out), .hit(a_hit), .multi_hit(a_mh), .out_q(a_out_q), .hit_q(a_hit_q)
  );

  // ---------------- instance B ----------------
  logic [2:0]  b_key;
  logic [27:0] b_lut;
  logic [3:0]  b_def;
  logic [3:0]  b_out, b_out_q;
  logic        b_hit, b_mh, b_hit_q;

  mux_key #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(4)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .key(b_key), .lut(b_lut),
`ifdef MUX_KEY_DEFAULT_EN
    .default_i(b_def),
`endif
    .out(b_out), .hit(b_hit), .multi_hit(b_mh), .out_q(b_out_q), .hit_q(b_hit_q)
  );

  // ---------------- instance C ----------------
  logic        c_key;
  logic [9:0]  c_lut;
  logic [3:0]  c_def;
  logic [3:0]  c_out, c_out_q;
  logic        c_hit, c_mh, c_hit_q;

  mux_key #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(4)) u_c (
    .clk_i(clk_i), .rst_i(rst_i), .key(c_key), .lut(c_lut),
`ifdef MUX_KEY_DEFAULT_EN
    .default_i(c_def),
`endif
    .out(c_out), .hit(c_hit), .multi_hit(c_mh), .out_q(c_out_q), .hit_q(c_hit_q)
  );

  // ---------------- instance D ----------------
  logic        d_key;
  logic [16:0] d_lut;
  logic [15:0] d_def;
  logic [15:0] d_out, d_out_q;
  logic        d_hit, d_mh, d_hit_q;

  mux_key #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(16)) u_d (
    .clk_i(clk_i), .rst_i(rst_i), .key(d_key), .lut(d_lut),
`ifdef MUX_KEY_DEFAULT_EN
    .default_i(d_def),
`endif
    .out(d_out), .hit(d_hit), .multi_hit(d_mh), .out_q(d_out_q), .hit_q(d_hit_q)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  // Table entry i is bits [(i+1)*W-1 : i*W]: key above, data below.
  function automatic void model(input logic [63:0] lut, input int nr, input int kl,
                                input int dl, input logic [31:0] k, input logic [31:0] dflt,
                                output logic [31:0] o, output logic h, output logic mh);
    int          n;
    int          w;
    logic [63:0] ent;
    logic [63:0] dmask;
    logic [63:0] acc;
    w     = kl + dl;
    n     = 0;
    acc   = '0;
    dmask = (64'd1 << dl) - 64'd1;
    for (int i = 0; i < nr; i++) begin
      ent = (lut >> (i * w)) & ((64'd1 << w) - 64'd1);
      if ((ent >> dl) == {32'd0, k}) begin
        n++;
        acc = acc | (ent & dmask);
      end
    end
    o  = acc[31:0];
    h  = (n > 0);
    mh = (n >= 2);
`ifdef MUX_KEY_DEFAULT_EN
    if (n == 0) o = dflt;
`else
    if (dflt != dflt) o = '0;  // default value unused when the feature is off
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge.
  // - Combinational outputs are checked 1 ns later.
  // - Registered outputs are checked 1 ns after the next rising edge.
  task automatic step_a(input string tag, input logic [1:0] k, input logic [39:0] l);
    logic [31:0] eo;
    logic        eh, emh;
    @(negedge clk_i);
    a_key = k;
    a_lut = l;
    a_def = 8'($urandom_range(0, 255));
    #1;
    model({24'd0, l}, 4, 2, 8, {30'd0, k}, {24'd0, a_def}, eo, eh, emh);
    check({tag, "_out"},   {24'd0, a_out}, eo);
    check({tag, "_hit"},   {31'd0, a_hit}, {31'd0, eh});
    check({tag, "_multi"}, {31'd0, a_mh},  {31'd0, emh});
    @(posedge clk_i);
    #1;
    check({tag, "_out_q"}, {24'd0, a_out_q}, eo);
    check({tag, "_hit_q"}, {31'd0, a_hit_q}, {31'd0, eh});
  endtask

  task automatic step_b(input string tag, input logic [2:0] k, input logic [27:0] l,
                        input logic [3:0] dflt);
    logic [31:0] eo;
    logic        eh, emh;
    @(negedge clk_i);
    b_key = k;
    b_lut = l;
    b_def = dflt;
    #1;
    model({36'd0, l}, 4, 3, 4, {29'd0, k}, {28'd0, dflt}, eo, eh, emh);
    check({tag, "_out"},   {28'd0, b_out}, eo);
    check({tag, "_hit"},   {31'd0, b_hit}, {31'd0, eh});
    check({tag, "_multi"}, {31'd0, b_mh},  {31'd0, emh});
    @(posedge clk_i);
    #1;
    check({tag, "_out_q"}, {28'd0, b_out_q}, eo);
    check({tag, "_hit_q"}, {31'd0, b_hit_q}, {31'd0, eh});
  endtask

  // ---------------- stimulus ----------------
  localparam logic [39:0] LUT_A = {2'b00, 8'h11, 2'b01, 8'h22, 2'b10, 8'h33, 2'b11, 8'h44};
  localparam logic [27:0] LUT_B = {3'd0, 4'b0000, 3'd1, 4'b0001, 3'd2, 4'b0011, 3'd3, 4'b1111};

  initial begin
    logic [31:0] eo;
    logic        eh, emh;
    logic [39:0] rl_a;
    logic [27:0] rl_b;

    a_key = 2'b10; a_lut = LUT_A; a_def = 8'h00;
    b_key = 3'd0;  b_lut = LUT_B; b_def = 4'h0;
    c_key = 1'b0;  c_lut = '0;    c_def = 4'h0;
    d_key = 1'b0;  d_lut = '0;    d_def = 16'h0;

    // Reset state: registers clear, combinational path is still live.
    #2;
    check("rst_out_q", {24'd0, a_out_q}, 32'h0);
    check("rst_hit_q", {31'd0, a_hit_q}, 32'h0);
    check("rst_comb_out", {24'd0, a_out}, 32'h33);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Directed lookup from the first configuration
    step_a("a_key2", 2'b10, LUT_A);
    check("a_key2_fixed_out_q", {24'd0, a_out_q}, 32'h33);
    check("a_key2_fixed_hit_q", {31'd0, a_hit_q}, 32'h1);

    // Sweep every key; out_q must follow the prior cycle's out.
    for (int k = 0; k < 4; k++) step_a("a_sweep", 2'(k), LUT_A);

    // Miss case on the second configuration
    step_b("b_miss", 3'd5, LUT_B, 4'hA);
`ifdef MUX_KEY_DEFAULT_EN
    check("b_miss_fixed_out", {28'd0, b_out}, 32'hA);
`else
    check("b_miss_fixed_out", {28'd0, b_out}, 32'h0);
`endif
    check("b_miss_fixed_hit", {31'd0, b_hit}, 32'h0);
    for (int k = 0; k < 8; k++) step_b("b_sweep", 3'(k), LUT_B, 4'h6);

    // Duplicate keys are OR-ed together.
    c_lut = {1'b1, 4'h3, 1'b1, 4'hC};
    c_key = 1'b1;
    #1;
    check("c_dup_out",   {28'd0, c_out}, 32'hF);
    check("c_dup_hit",   {31'd0, c_hit}, 32'h1);
    check("c_dup_multi", {31'd0, c_mh},  32'h1);
    c_key = 1'b0;
    c_def = 4'h5;
    #1;
`ifdef MUX_KEY_DEFAULT_EN
    check("c_miss_out", {28'd0, c_out}, 32'h5);
`else
    check("c_miss_out", {28'd0, c_out}, 32'h0);
`endif
    check("c_miss_multi", {31'd0, c_mh}, 32'h0);

    // Single-entry table
    d_lut = {1'b0, 16'hBEEF};
    d_def = 16'h1234;
    d_key = 1'b0;
    #1;
    check("d_hit_out", {16'd0, d_out}, 32'hBEEF);
    check("d_hit_multi", {31'd0, d_mh}, 32'h0);
    d_key = 1'b1;
    #1;
`ifdef MUX_KEY_DEFAULT_EN
    check("d_miss_out", {16'd0, d_out}, 32'h1234);
`else
    check("d_miss_out", {16'd0, d_out}, 32'h0);
`endif
    check("d_miss_hit", {31'd0, d_hit}, 32'h0);
    check("d_miss_multi", {31'd0, d_mh}, 32'h0);

    // Asynchronous reset between clock edges
    @(negedge clk_i);
    a_key = 2'b11;
    a_lut = LUT_A;
    @(posedge clk_i);
    #1;
    check("arst_pre_out_q", {24'd0, a_out_q}, 32'h44);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_out_q", {24'd0, a_out_q}, 32'h0);
    check("arst_hit_q", {31'd0, a_hit_q}, 32'h0);
    check("arst_out",   {24'd0, a_out},   32'h44);
    check("arst_hit",   {31'd0, a_hit},   32'h1);
    @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("arst_rel_out_q", {24'd0, a_out_q}, 32'h0);
    @(posedge clk_i);
    #1;
    check("arst_load_out_q", {24'd0, a_out_q}, 32'h44);
    check("arst_load_hit_q", {31'd0, a_hit_q}, 32'h1);

    // Randomized tables and keys (random tables often carry duplicate keys)
    for (int n = 0; n < 150; n++) begin
      rl_a = {8'($urandom), $urandom};
      step_a("a_rand", 2'($urandom_range(0, 3)), rl_a);
    end
    for (int n = 0; n < 150; n++) begin
      rl_b = 28'($urandom);
      step_b("b_rand", 3'($urandom_range(0, 7)), rl_b, 4'($urandom_range(0, 15)));
    end

    // Reference-model cross-check of C with random tables
    for (int n = 0; n < 40; n++) begin
      c_lut = 10'($urandom);
      c_key = 1'($urandom_range(0, 1));
      c_def = 4'($urandom_range(0, 15));
      #1;
      model({54'd0, c_lut}, 2, 1, 4, {31'd0, c_key}, {28'd0, c_def}, eo, eh, emh);
      check("c_rand_out",   {28'd0, c_out}, eo);
      check("c_rand_hit",   {31'd0, c_hit}, {31'd0, eh});
      check("c_rand_multi", {31'd0, c_mh},  {31'd0, emh});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
